// File: rtl/cpu_inta_sequencer.sv
// CPU-side INTA master: synchronises the controller's INT, issues the
// interrupt_acknowledge_n pulse train and captures the returned bytes.
module cpu_inta_sequencer #(
   parameter int INTA_LOW_CYCLES = 2,
   parameter int INTA_GAP_CYCLES = 2,
   parameter bit MODE_8086       = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        interrupt_to_cpu,
   input  logic        cpu_ready,
   input  logic [7:0]  data_bus_in,
   output logic        interrupt_acknowledge_n,
   output logic        busy,
   output logic        vector_valid,
   output logic [7:0]  vector,
   output logic [15:0] call_address,
   output logic        protocol_error
);

   localparam int NPULSE = MODE_8086 ? 2 : 3;
   localparam int CMAX   = (INTA_LOW_CYCLES > INTA_GAP_CYCLES) ? INTA_LOW_CYCLES : INTA_GAP_CYCLES;
   localparam int CW     = (CMAX < 2) ? 1 : $clog2(CMAX);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PULSE = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [CW-1:0] LOW_LAST = CW'(INTA_LOW_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(INTA_GAP_CYCLES - 1);
   localparam logic [1:0]    P_LAST   = 2'(NPULSE - 1);

   logic [1:0]    state;
   logic [1:0]    sync;
   logic [CW-1:0] c;
   logic [1:0]    p;
   logic          err;
   logic          int_s;

   assign int_s = sync[1];

   always_ff @(posedge clk) begin
      if (reset) begin
         state                   <= S_IDLE;
         sync                    <= 2'b00;
         c                       <= '0;
         p                       <= 2'd0;
         err                     <= 1'b0;
         interrupt_acknowledge_n <= 1'b1;
         vector                  <= 8'h00;
         call_address            <= 16'h0000;
      end else begin
         sync <= {sync[0], interrupt_to_cpu};
         case (state)
            S_IDLE: begin
               if (int_s && cpu_ready) begin
                  state                   <= S_PULSE;
                  p                       <= 2'd0;
                  c                       <= '0;
                  err                     <= 1'b0;
                  interrupt_acknowledge_n <= 1'b0;
               end
            end
            S_PULSE: begin
               if (c == LOW_LAST) begin
                  // Last low cycle: the controller's byte is stable on the bus.
                  c <= '0;
                  interrupt_acknowledge_n <= 1'b1;
                  if (MODE_8086) begin
                     if (p == 2'd1) vector <= data_bus_in;
                  end else begin
                     case (p)
                        2'd0:    err                <= (data_bus_in != 8'hCD);
                        2'd1:    call_address[7:0]  <= data_bus_in;
                        default: call_address[15:8] <= data_bus_in;
                     endcase
                  end
                  state <= (p == P_LAST) ? S_DONE : S_GAP;
               end else begin
                  c <= c + 1'b1;
               end
            end
            S_GAP: begin
               if (c == GAP_LAST) begin
                  c                       <= '0;
                  p                       <= p + 2'd1;
                  state                   <= S_PULSE;
                  interrupt_acknowledge_n <= 1'b0;
               end else begin
                  c <= c + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy           = (state != S_IDLE);
   assign vector_valid   = (state == S_DONE);
   assign protocol_error = (state == S_DONE) && err;

endmodule
